// File: rtl/inv_meter_pkg.sv
// Shared types and default sizing for the inverter frequency meter.
package inv_meter_pkg;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_GATE_W      = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a history flop
// that yields a one-cycle pulse per rising edge.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/inverter_freq_meter.sv
// Gated rising-edge counter for the looped-back analog inverter output, with a
// byte-wide readout mux for the tile output bus.
module inverter_freq_meter #(
    parameter int unsigned CNT_W       = inv_meter_pkg::DEF_CNT_W,
    parameter int unsigned GATE_W      = inv_meter_pkg::DEF_GATE_W,
    parameter int unsigned SYNC_STAGES = inv_meter_pkg::DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              sig_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              rd_hi,
    output logic [CNT_W-1:0]  count,
    output logic [7:0]        dout,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    import inv_meter_pkg::*;

    meter_state_t      r_state;
    meter_state_t      w_next;
    logic [GATE_W-1:0] r_gate;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              w_edge;
    logic              w_accept;
    logic              w_counting;
    logic [15:0]       w_cnt16;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_sig   (sig_in),
        .o_edge  (w_edge)
    );

    // A start is honoured from IDLE and DONE alike; COUNT ignores it.
    assign w_accept   = ena && start && (r_state != ST_COUNT);
    assign w_counting = ena && (r_state == ST_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!ena) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_next = (gate_len == '0) ? ST_DONE : ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (r_gate == GATE_W'(1)) begin
                        w_next = ST_DONE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_gate  <= gate_len;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_counting) begin
            r_gate <= r_gate - GATE_W'(1);
            if (w_edge) begin
                if (&r_count) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    // Resize to 16 bits so the byte mux works for any counter width.
    assign w_cnt16 = 16'(r_count);

    assign count = r_count;
    assign dout  = rd_hi ? w_cnt16[15:8] : w_cnt16[7:0];
    assign busy  = (r_state == ST_COUNT);
    assign done  = (r_state == ST_DONE);
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_inverter_freq_meter.sv
// Directed self-checking bench for inverter_freq_meter (default and 4-bit counter builds).
module tb_inverter_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n, ena;
    logic        sig_a, start_a, rd_hi_a;
    logic [15:0] gate_a, count_a;
    logic [7:0]  dout_a;
    logic        busy_a, done_a, ovf_a;
    logic        sig_b, start_b, rd_hi_b;
    logic [15:0] gate_b;
    logic [3:0]  count_b;
    logic [7:0]  dout_b;
    logic        busy_b, done_b, ovf_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int per_a  = 10;
    int per_b  = 4;
    int busy_n;
    int done_k;

    always #5 clk = ~clk;

    inverter_freq_meter dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_a), .start(start_a),
        .gate_len(gate_a), .rd_hi(rd_hi_a), .count(count_a), .dout(dout_a),
        .busy(busy_a), .done(done_a), .ovf(ovf_a)
    );

    inverter_freq_meter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_b), .start(start_b),
        .gate_len(gate_b), .rd_hi(rd_hi_b), .count(count_b), .dout(dout_b),
        .busy(busy_b), .done(done_b), .ovf(ovf_b)
    );

    // per_a == 0 leaves sig_a under direct manual control.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (per_a != 0) sig_a = ((cyc % per_a) < (per_a / 2));
        sig_b = ((cyc % per_b) < (per_b / 2));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0;
        sig_a = 1'b0; start_a = 1'b0; gate_a = '0; rd_hi_a = 1'b0;
        sig_b = 1'b0; start_b = 1'b0; gate_b = '0; rd_hi_b = 1'b0;
        repeat (3) step();
        check("rst_count", count_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovf", ovf_a, 0);
        rst_n = 1'b1; ena = 1'b1;
        repeat (20) step();

        // basic count: period 10, gate 100
        gate_a = 16'd100; start_a = 1'b1;
        step();
        start_a = 1'b0; gate_a = 16'd3;
        check("basic_busy_first", busy_a, 1);
        check("basic_done_first", done_a, 0);
        busy_n = 1; done_k = 0;
        for (int k = 1; k <= 150; k++) begin
            step();
            if (done_a) begin done_k = k; break; end
            if (busy_a) busy_n++;
        end
        check("basic_done_latency", done_k, 100);
        check("basic_busy_cycles", busy_n, 100);
        check("basic_count", count_a, 10);
        check("basic_busy_end", busy_a, 0);
        check("basic_dout_lo", dout_a, 10);
        step();
        check("basic_done_sticky", done_a, 1);
        check("basic_count_frozen", count_a, 10);

        // zero gate, restarted from DONE
        gate_a = 16'd0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("zero_done", done_a, 1);
        check("zero_busy", busy_a, 0);
        check("zero_count", count_a, 0);
        step();
        check("zero_busy_after", busy_a, 0);
        check("zero_done_after", done_a, 1);

        // start held through COUNT
        gate_a = 16'd20; start_a = 1'b1;
        step();
        busy_n = 1; done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done_a) begin done_k = k; break; end
            if (busy_a) busy_n++;
        end
        check("held_done_latency", done_k, 20);
        check("held_busy_cycles", busy_n, 20);
        check("held_count", count_a, 2);
        step();
        check("held_restart_busy", busy_a, 1);
        check("held_restart_done", done_a, 0);
        check("held_restart_count", count_a, 0);
        start_a = 1'b0;
        repeat (25) step();
        check("held_second_done", done_a, 1);
        check("held_second_count", count_a, 2);

        // ena abort with three manual pulses
        per_a = 0; sig_a = 1'b0;
        repeat (5) step();
        gate_a = 16'd100; start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig_a = 1'b1; step(); step();
            sig_a = 1'b0; step(); step();
        end
        repeat (4) step();
        check("abort_busy_before", busy_a, 1);
        check("abort_count_before", count_a, 3);
        ena = 1'b0;
        step();
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_count_held", count_a, 3);
        repeat (3) step();
        check("abort_count_still", count_a, 3);
        ena = 1'b1;
        step();

        // readout of 0x1234: period 4 over 18640 cycles
        per_a = 4;
        repeat (20) step();
        gate_a = 16'd18640; start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (18645) step();
        check("read_done", done_a, 1);
        check("read_count", count_a, 32'h1234);
        rd_hi_a = 1'b0; #1;
        check("read_dout_lo", dout_a, 8'h34);
        rd_hi_a = 1'b1; #1;
        check("read_dout_hi", dout_a, 8'h12);
        rd_hi_a = 1'b0;

        // saturation on the 4-bit build
        gate_b = 16'd100; start_b = 1'b1;
        step();
        start_b = 1'b0;
        repeat (105) step();
        check("sat_done", done_b, 1);
        check("sat_count", count_b, 15);
        check("sat_ovf", ovf_b, 1);
        gate_b = 16'd8; start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("sat2_ovf_cleared", ovf_b, 0);
        check("sat2_busy", busy_b, 1);
        repeat (10) step();
        check("sat2_done", done_b, 1);
        check("sat2_count", count_b, 2);
        check("sat2_ovf", ovf_b, 0);
        check("sat2_dout", dout_b, 2);

        // reset in the middle of COUNT
        per_a = 10;
        repeat (20) step();
        gate_a = 16'd200; start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (40) step();
        check("mid_busy", busy_a, 1);
        check("mid_count", count_a, 4);
        rst_n = 1'b0; #1;
        check("mid_rst_count", count_a, 0);
        check("mid_rst_dout", dout_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_ovf", ovf_a, 0);
        step();
        rst_n = 1'b1;
        step(); step();
        check("post_rst_busy", busy_a, 0);
        check("post_rst_done", done_a, 0);
        check("post_rst_count", count_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inverter_freq_meter.md
# inverter_freq_meter

Digital measurement stage directly downstream of the analog inverter macro: the inverter output, looped back onto a dedicated digital input, is synchronized, rising-edge detected and counted over a programmable gate window of `clk` cycles. The result is exposed byte-wise for the tile's `uo_out` bus. This gives the analog inverter (or a ring oscillator built from it) an on-chip frequency/toggle readout without external instruments.

## Interface

**Parameters**
- `CNT_W`, default 16: edge-counter width; result saturates at 2^CNT_W−1.
- `GATE_W`, default 16: width of the gate-length input.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on `sig_in`; minimum 2.

**Ports**
- `clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `ena` in 1: tile enable; low aborts to IDLE.
- `sig_in` in 1: asynchronous inverter output under measurement.
- `start` in 1: level-sampled start request.
- `gate_len` in `GATE_W`: gate window length in `clk` cycles, latched on accepted start.
- `rd_hi` in 1: byte select for `dout`; 1 selects `count[15:8]`, 0 selects `count[7:0]`.
- `count` out `CNT_W`: last measurement result.
- `dout` out 8: combinational byte mux of `count`.
- `busy` out 1: high while in COUNT.
- `done` out 1: sticky result-valid flag.
- `ovf` out 1: sticky counter-saturation flag for the last measurement.

## Operation

- Synchronizer: `SYNC_STAGES` flops followed by one history flop. The edge pulse is `sync & ~hist`, one cycle wide per rising edge of `sig_in`.
- FSM states:
  - **IDLE**: `start`=1 with `ena`=1 → latch `gate_len` into the gate counter, clear `count`/`ovf`/`done`, go to COUNT. If latched `gate_len`=0 → go directly to DONE with `count`=0.
  - **COUNT**: each cycle, an edge pulse increments `count`. If `count` is already all-ones, it holds and sets `ovf`. The gate counter decrements each cycle; in the cycle it reaches 1 (the last window cycle, whose edge pulse still counts) → DONE.
  - **DONE**: `done`=1 and `count` frozen. `start`=1 → restarts exactly as from IDLE.
- `start` during COUNT is ignored. `gate_len` changes after acceptance are ignored.
- `ena`=0 in any state → IDLE next cycle, `done` cleared, `count` retained.
- Edge pulses occurring in IDLE or DONE are not counted.
- Reset mid-operation: all state and outputs return to reset values immediately.

## Timing

- Reset values: state IDLE, `count`=0, `dout`=0, `busy`=0, `done`=0, `ovf`=0, synchronizer/history flops 0.
- `start` accepted at clock edge t → COUNT during cycles t+1 … t+N, where N is the latched `gate_len`. Edge pulses present in exactly those N cycles are counted.
- `busy`=1 in cycles t+1 … t+N. `done`=1 and final `count` visible from cycle t+N+1.
- `gate_len`=0: `done`=1 at cycle t+1, `count`=0, `busy` never asserts.
- A `sig_in` rising edge reaches the edge pulse SYNC_STAGES+1 cycles after it is first sampled. Counting is reliable for `sig_in` frequency below f_clk/2.
- `dout` follows `count` and `rd_hi` combinationally, with no added latency.

## Structure

- Shared package `inv_meter_pkg`: FSM state enum (IDLE, COUNT, DONE) and default width constants (`CNT_W`, `GATE_W`, `SYNC_STAGES`).
- One sub-module, `sync_edge_detect`: parameterized synchronizer plus rising-edge detector; the top level instantiates it once.
- Top level contains the FSM, gate counter, saturating edge counter and output mux.

## Test plan

- **Reset**: assert `rst_n`=0 mid-COUNT → all outputs 0 in the same cycle; FSM back in IDLE after release.
- **Basic count**: `sig_in` = square wave with period 10 `clk`, `gate_len`=100, pulse `start` → `done` at t+101, `count`=10 (±1 allowed for phase), `busy` high exactly 100 cycles.
- **Zero gate**: `gate_len`=0, `start` → `done`=1 next cycle, `count`=0, `busy` stays 0.
- **Saturation**: `CNT_W`=4, `sig_in` period 4, `gate_len`=100 → `count`=15, `ovf`=1. A following start with `gate_len`=8 → `ovf` cleared, `count`=2.
- **Ignored start / ena abort**: `start` held high through COUNT → exactly one measurement, then immediate restart from DONE. `ena`=0 mid-COUNT → IDLE, `done`=0, `count` holds its partial value.
- **Readout**: `count`=0x1234 → `dout`=0x34 with `rd_hi`=0, `dout`=0x12 with `rd_hi`=1, same cycle.
